rvsteel_uart_fifo: RTL

Buffered, run-time-configurable UART peripheral for the RISC-V Steel memory-mapped IO bus. It is the next generation of the single-byte UART: it adds independent TX/RX FIFOs of parametrised depth, a software-writable baud divisor, sticky error flags, and maskable level interrupts. It sits on the system bus as a slave at `BASE_ADDRESS` and drives the board `uart_tx`/`uart_rx` pins.

---
 rtl/rvsteel_uart_fifo_if.sv | 20 ++
 rtl/rvsteel_uart_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_uart_fifo_if.sv
// Memory-mapped IO bus of the RISC-V Steel system: the core is the master and each peripheral is a slave.
interface rvsteel_uart_fifo_if;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address, read_request, write_data, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  rw_address, read_request, write_data, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/rvsteel_uart_fifo.sv
// Buffered UART for the RISC-V Steel IO bus: TX/RX FIFOs, software baud divisor,
// sticky error flags and maskable level interrupt.
module rvsteel_uart_fifo #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [31:0] BASE_ADDRESS    = 32'h80000000
) (
  input  logic               clock,
  input  logic               reset_n,
  rvsteel_uart_fifo_if.slave bus,
  input  logic               uart_rx,
  output logic               uart_tx,
  output logic               uart_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RESET = 16'(CLOCK_FREQUENCY / UART_BAUD_RATE);
  localparam int TXF = 0;
  localparam int RXF = 1;

  // ---------------------------------------------------------------- decode
  logic sel_data, sel_status, sel_divisor, sel_irq_en;
  assign sel_data    = bus.rw_address == BASE_ADDRESS;
  assign sel_status  = bus.rw_address == BASE_ADDRESS + 32'h4;
  assign sel_divisor = bus.rw_address == BASE_ADDRESS + 32'h8;
  assign sel_irq_en  = bus.rw_address == BASE_ADDRESS + 32'hC;

  logic unused_bits;
  assign unused_bits = ^bus.write_data[31:16];

  // ---------------------------------------------------------------- FIFOs
  logic          fifo_push  [2];
  logic          fifo_pop   [2];
  logic [7:0]    fifo_wdata [2];
  logic [7:0]    fifo_rdata [2];
  logic          fifo_full  [2];
  logic          fifo_empty [2];
  logic [CW-1:0] rx_count;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;
      logic          push_ok;
      logic          pop_ok;

      // Fullness uses the pre-cycle count, so a simultaneous pop never makes room.
      assign fifo_full[gi]  = count_reg == DEPTH_C;
      assign fifo_empty[gi] = count_reg == '0;
      assign push_ok        = fifo_push[gi] && !fifo_full[gi];
      assign pop_ok         = fifo_pop[gi] && !fifo_empty[gi];
      assign fifo_rdata[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg] <= fifo_wdata[gi];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
      end

      if (gi == RXF) begin : g_rx_count
        assign rx_count = count_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------- registers
  logic [15:0] divisor_reg;
  logic [2:0]  irq_en_reg;
  logic        rx_overrun_reg;
  logic        frame_error_reg;
  logic [31:0] read_data_reg;
  logic [31:0] read_data_next;
  logic        read_response_reg;
  logic        write_response_reg;
  logic        uart_irq_reg;
  logic        irq_next;
  logic [7:0]  rx_count_byte;
  logic [31:0] status_word;
  logic        tx_pop;
  logic        tx_idle;
  logic        rx_push_reg;
  logic [7:0]  rx_byte_reg;
  logic        rx_overrun_set;
  logic        frame_error_set;

  assign fifo_push[TXF]  = bus.write_request && sel_data;
  assign fifo_wdata[TXF] = bus.write_data[7:0];
  assign fifo_pop[TXF]   = tx_pop;
  assign fifo_push[RXF]  = rx_push_reg;
  assign fifo_wdata[RXF] = rx_byte_reg;
  assign fifo_pop[RXF]   = bus.read_request && sel_data;

  assign rx_overrun_set = rx_push_reg && fifo_full[RXF];
  assign rx_count_byte  = 8'(rx_count);
  assign status_word    = {16'h0, rx_count_byte, 2'b00, frame_error_reg, rx_overrun_reg,
                           fifo_empty[RXF], fifo_full[RXF], fifo_empty[TXF], fifo_full[TXF]};

  always_comb begin
    read_data_next = 32'h0;
    if (sel_data && !fifo_empty[RXF]) read_data_next = {24'h0, fifo_rdata[RXF]};
    else if (sel_status)              read_data_next = status_word;
    else if (sel_divisor)             read_data_next = {16'h0, divisor_reg};
    else if (sel_irq_en)              read_data_next = {29'h0, irq_en_reg};
  end

  assign irq_next = (irq_en_reg[0] && !fifo_empty[RXF]) ||
                    (irq_en_reg[1] && fifo_empty[TXF] && tx_idle) ||
                    (irq_en_reg[2] && (rx_overrun_reg || frame_error_reg));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      divisor_reg        <= DIV_RESET;
      irq_en_reg         <= 3'b000;
      rx_overrun_reg     <= 1'b0;
      frame_error_reg    <= 1'b0;
      read_data_reg      <= 32'h0;
      read_response_reg  <= 1'b0;
      write_response_reg <= 1'b0;
      uart_irq_reg       <= 1'b0;
    end else begin
      read_response_reg  <= bus.read_request;
      write_response_reg <= bus.write_request;
      uart_irq_reg       <= irq_next;
      if (bus.read_request) read_data_reg <= read_data_next;
      if (bus.write_request && sel_divisor)
        divisor_reg <= (bus.write_data[15:0] < 16'd4) ? 16'd4 : bus.write_data[15:0];
      if (bus.write_request && sel_irq_en) irq_en_reg <= bus.write_data[2:0];
      // Clear before set so a new error in the same cycle is never lost.
      if (bus.write_request && sel_status && bus.write_data[4]) rx_overrun_reg  <= 1'b0;
      if (bus.write_request && sel_status && bus.write_data[5]) frame_error_reg <= 1'b0;
      if (rx_overrun_set)  rx_overrun_reg  <= 1'b1;
      if (frame_error_set) frame_error_reg <= 1'b1;
    end
  end

  assign bus.read_data      = read_data_reg;
  assign bus.read_response  = read_response_reg;
  assign bus.write_response = write_response_reg;
  assign uart_irq           = uart_irq_reg;

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_div_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        tx_bit_done;
  logic        tx_line_next;
  logic        uart_tx_reg;

  assign tx_bit_done = tx_cnt_reg == tx_div_reg - 16'd1;
  assign tx_idle     = tx_state_reg == TX_IDLE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tx_state_reg <= TX_IDLE;
    else          tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!fifo_empty[TXF]) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_bit_done && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_done) begin
          if (!fifo_empty[TXF]) begin
            tx_pop        = 1'b1;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line_next = 1'b1;
    case (tx_state_reg)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_shift_reg[0];
      default:  tx_line_next = 1'b1;
    endcase
  end

  // The divisor is captured at the pop so a mid-frame rewrite only affects later frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_div_reg   <= DIV_RESET;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      uart_tx_reg  <= 1'b1;
    end else begin
      uart_tx_reg <= tx_line_next;
      if (tx_pop) begin
        tx_div_reg   <= divisor_reg;
        tx_shift_reg <= fifo_rdata[TXF];
        tx_cnt_reg   <= 16'd0;
        tx_bit_reg   <= 3'd0;
      end else if (tx_state_reg != TX_IDLE) begin
        if (tx_bit_done) begin
          tx_cnt_reg <= 16'd0;
          if (tx_state_reg == TX_DATA) begin
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_bit_reg   <= tx_bit_reg + 3'd1;
          end
        end else begin
          tx_cnt_reg <= tx_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign uart_tx = uart_tx_reg;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [1:0]  rx_sync_reg;
  logic        rx_prev_reg;
  logic [15:0] rx_div_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_line;
  logic        rx_fall;
  logic        rx_half_done;
  logic        rx_bit_done;
  logic        rx_accept;

  assign rx_line      = rx_sync_reg[1];
  assign rx_fall      = rx_prev_reg && !rx_line;
  assign rx_half_done = rx_cnt_reg == (rx_div_reg >> 1) - 16'd1;
  assign rx_bit_done  = rx_cnt_reg == rx_div_reg - 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_state_reg <= RX_IDLE;
    else          rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      RX_START: if (rx_half_done) rx_state_next = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_done && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_bit_done) rx_state_next = rx_line ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_line) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_accept       = 1'b0;
    frame_error_set = 1'b0;
    if (rx_state_reg == RX_STOP && rx_bit_done) begin
      rx_accept       = rx_line;
      frame_error_set = !rx_line;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_reg  <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_div_reg   <= DIV_RESET;
      rx_cnt_reg   <= 16'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_push_reg  <= 1'b0;
      rx_byte_reg  <= 8'h00;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], uart_rx};
      rx_prev_reg <= rx_line;
      rx_push_reg <= rx_accept;
      if (rx_accept) rx_byte_reg <= rx_shift_reg;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_div_reg <= divisor_reg;
            rx_cnt_reg <= 16'd0;
            rx_bit_reg <= 3'd0;
          end
        end
        RX_START: rx_cnt_reg <= rx_half_done ? 16'd0 : rx_cnt_reg + 16'd1;
        RX_DATA, RX_STOP: begin
          if (rx_bit_done) begin
            rx_cnt_reg <= 16'd0;
            if (rx_state_reg == RX_DATA) begin
              rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
              rx_bit_reg   <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        default: rx_cnt_reg <= 16'd0;
      endcase
    end
  end

endmodule
